// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg : shared BCD digit type, limits and helpers for the BCD counter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;

   function automatic logic is_bcd(input bcd_digit_t d);
      return (d <= BCD_MAX);
   endfunction

   // Only meaningful for BCD digits; 99 is the largest result and fits in 7 bits.
   function automatic logic [6:0] to_bin(input bcd_digit_t tens, input bcd_digit_t ones);
      return ({3'b000, tens} * 7'd10) + {3'b000, ones};
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit : one decade cell with load, increment, decrement and carry/borrow
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_digit
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       dec,
   input  logic       load,
   input  bcd_digit_t load_val,
   input  bcd_digit_t wrap_to,
   output bcd_digit_t q,
   output logic       carry
);

   // Carry on 9->0 going up, borrow on 0->wrap_to going down.
   assign carry = (inc && (q == BCD_MAX)) || (dec && (q == 4'd0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= 4'd0;
      end else if (load) begin
         q <= load_val;
      end else if (inc) begin
         q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
      end else if (dec) begin
         q <= (q == 4'd0) ? wrap_to : q - 4'd1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/bcd_counter.sv
// ---------------------------------------------------------------------------
// bcd_counter : two-digit modulo-MODULO BCD counter with prescaler and load
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_counter
   import bcd_pkg::*;
#(
   parameter int PRESCALE = 4,
   parameter int MODULO   = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       up,
   input  logic       load,
   input  logic [3:0] load_tens,
   input  logic [3:0] load_ones,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       step,
   output logic       tc,
   output logic       load_err
);

   localparam int         PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
   localparam bcd_digit_t MAX_TENS = bcd_digit_t'((MODULO - 1) / 10);
   localparam bcd_digit_t MAX_ONES = bcd_digit_t'((MODULO - 1) % 10);
   localparam logic [6:0] MAX_BIN  = 7'(MODULO - 1);
   localparam logic [6:0] MOD_BIN  = 7'(MODULO);

   logic [PW-1:0] pcnt;
   logic          load_ok;
   logic          step_now;
   logic          wrap;
   logic          digit_load;
   bcd_digit_t    tens_val;
   bcd_digit_t    ones_val;
   logic          ones_inc;
   logic          ones_dec;
   logic          ones_carry;
   logic          tens_carry;

   assign load_ok  = is_bcd(load_tens) && is_bcd(load_ones) &&
                     (to_bin(load_tens, load_ones) < MOD_BIN);
   assign step_now = en && !load && (pcnt == PCNT_LAST);
   assign wrap     = step_now && (up ? (to_bin(tens, ones) == MAX_BIN)
                                     : (to_bin(tens, ones) == 7'd0));

   // Modulo wrap reuses the digit load path so the cells stay plain decades.
   assign digit_load = (load && load_ok) || wrap;
   assign tens_val   = load ? load_tens : (up ? 4'd0 : MAX_TENS);
   assign ones_val   = load ? load_ones : (up ? 4'd0 : MAX_ONES);
   assign ones_inc   = step_now && up && !wrap;
   assign ones_dec   = step_now && !up && !wrap;

   bcd_digit u_ones (
      .clk      (clk),
      .rst      (rst),
      .inc      (ones_inc),
      .dec      (ones_dec),
      .load     (digit_load),
      .load_val (ones_val),
      .wrap_to  (BCD_MAX),
      .q        (ones),
      .carry    (ones_carry)
   );

   bcd_digit u_tens (
      .clk      (clk),
      .rst      (rst),
      .inc      (ones_carry && up),
      .dec      (ones_carry && !up),
      .load     (digit_load),
      .load_val (tens_val),
      .wrap_to  (BCD_MAX),
      .q        (tens),
      .carry    (tens_carry)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt     <= '0;
         step     <= 1'b0;
         tc       <= 1'b0;
         load_err <= 1'b0;
      end else begin
         step     <= step_now;
         tc       <= wrap;
         load_err <= load && !load_ok;
         if (load) begin
            if (load_ok) pcnt <= '0;
         end else if (en) begin
            pcnt <= (pcnt == PCNT_LAST) ? '0 : pcnt + PW'(1);
         end
      end
   end

   // The tens carry out has no consumer beyond two digits.
   logic unused_carry;
   assign unused_carry = tens_carry;

endmodule

`default_nettype wire

// File: tb/tb_bcd_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_counter : directed checks for bcd_counter (60/4 and 100/1 builds)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bcd_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0, up = 1'b1, load = 1'b0;
   logic [3:0] load_tens = 4'd0, load_ones = 4'd0;
   logic [3:0] tens, ones;
   logic       step, tc, load_err;

   logic       en1 = 1'b0, up1 = 1'b1;
   logic [3:0] tens1, ones1;
   logic       step1, tc1, load_err1;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   bcd_counter #(.PRESCALE(4), .MODULO(60)) dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .load_tens(load_tens), .load_ones(load_ones),
      .tens(tens), .ones(ones), .step(step), .tc(tc), .load_err(load_err)
   );

   bcd_counter #(.PRESCALE(1), .MODULO(100)) dut1 (
      .clk(clk), .rst(rst), .en(en1), .up(up1), .load(1'b0),
      .load_tens(4'd0), .load_ones(4'd0),
      .tens(tens1), .ones(ones1), .step(step1), .tc(tc1), .load_err(load_err1)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_load(input logic [3:0] t, input logic [3:0] o);
      load = 1'b1; load_tens = t; load_ones = o;
      tick();
      load = 1'b0;
   endtask

   function automatic int val(input logic [3:0] t, input logic [3:0] o);
      return 10 * int'(t) + int'(o);
   endfunction

   int tcs, steps;

   initial begin
      ticks(2);
      rst = 1'b0;
      check("reset_value", val(tens, ones), 0);
      check("reset_step", step, 0);
      check("reset_tc", tc, 0);
      check("reset_err", load_err, 0);

      // Prescaled up-count from reset: steps on edges 4, 8, 12.
      en = 1'b1; up = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         check($sformatf("pre_step_%0d", k), step, (k % 4 == 0) ? 1 : 0);
         if (k % 4 == 0) check($sformatf("pre_val_%0d", k), val(tens, ones), k / 4);
      end

      // Prescaler holds while en is low.
      ticks(2);
      en = 1'b0;
      ticks(3);
      check("hold_step", step, 0);
      en = 1'b1;
      tick();
      check("hold_no_step", step, 0);
      tick();
      check("hold_step_val", val(tens, ones), 4);
      check("hold_step_pulse", step, 1);

      do_load(4'd5, 4'd9);
      check("load59", val(tens, ones), 59);
      ticks(4);
      check("wrap_up_val", val(tens, ones), 0);
      check("wrap_up_tc", tc, 1);
      tick();
      check("wrap_up_tc_clear", tc, 0);

      do_load(4'd0, 4'd9);
      ticks(4);
      check("carry_val", val(tens, ones), 10);
      check("carry_tc", tc, 0);

      up = 1'b0;
      do_load(4'd1, 4'd0);
      ticks(4);
      check("borrow_val", val(tens, ones), 9);
      do_load(4'd0, 4'd0);
      ticks(4);
      check("wrap_dn_val", val(tens, ones), 59);
      check("wrap_dn_tc", tc, 1);

      // Rejected loads.
      en = 1'b0; up = 1'b1;
      do_load(4'd6, 4'd0);
      check("bad60_val", val(tens, ones), 59);
      check("bad60_err", load_err, 1);
      tick();
      check("bad60_err_clear", load_err, 0);
      do_load(4'd0, 4'hA);
      check("badA_val", val(tens, ones), 59);
      check("badA_err", load_err, 1);

      // Valid load clears a partially advanced prescaler.
      en = 1'b1;
      ticks(2);
      do_load(4'd4, 4'd2);
      check("load42_val", val(tens, ones), 42);
      check("load42_err", load_err, 0);
      ticks(3);
      check("load42_nostep", step, 0);
      tick();
      check("load42_step", step, 1);
      check("load42_next", val(tens, ones), 43);

      // Load on a would-be step cycle wins.
      ticks(3);
      do_load(4'd2, 4'd5);
      check("prio_val", val(tens, ones), 25);
      check("prio_step", step, 0);
      check("prio_tc", tc, 0);
      ticks(4);
      check("prio_next", val(tens, ones), 26);

      // Rejected load on a would-be step cycle holds the prescaler.
      ticks(3);
      do_load(4'd9, 4'd9);
      check("badprio_val", val(tens, ones), 26);
      check("badprio_err", load_err, 1);
      check("badprio_step", step, 0);
      tick();
      check("badprio_late_step", step, 1);
      check("badprio_late_val", val(tens, ones), 27);

      // Asynchronous reset mid-count.
      do_load(4'd3, 4'd6);
      ticks(4);
      check("pre_rst_val", val(tens, ones), 37);
      #2 rst = 1'b1;
      #1;
      check("async_val", val(tens, ones), 0);
      check("async_step", step, 0);
      check("async_tc", tc, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      en = 1'b0;

      // PRESCALE=1, MODULO=100 full up sweep.
      en1 = 1'b1; up1 = 1'b1;
      tcs = 0; steps = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (tc1) tcs++;
         if (step1) steps++;
         if (i == 98) begin
            check("sweep_up_99", val(tens1, ones1), 99);
            check("sweep_up_tc_before", tcs, 0);
         end
         if (i == 99) begin
            check("sweep_up_wrap_val", val(tens1, ones1), 0);
            check("sweep_up_wrap_tc", tc1, 1);
         end
      end
      check("sweep_up_tcs", tcs, 2);
      check("sweep_up_steps", steps, 200);
      check("sweep_up_end", val(tens1, ones1), 0);

      up1 = 1'b0;
      tcs = 0;
      tick();
      if (tc1) tcs++;
      check("sweep_dn_first", val(tens1, ones1), 99);
      check("sweep_dn_first_tc", tc1, 1);
      for (int i = 0; i < 99; i++) begin
         tick();
         if (tc1) tcs++;
         if (i == 48) check("sweep_dn_mid", val(tens1, ones1), 50);
      end
      check("sweep_dn_tcs", tcs, 1);
      check("sweep_dn_end", val(tens1, ones1), 0);
      check("sweep_err", load_err1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
